// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// 32-cycle hardware CLEAR sequence that zeroes every register.
module regfile_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IDW         = 2,
    parameter bit SUPPRESS_R0 = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear_start,
    output logic                    clear_busy,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [5*NUM_REQ-1:0]    addr_flat,
    input  logic [32*NUM_REQ-1:0]   data_flat,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    dec_enable,
    output logic [4:0]              dec_sel,
    output logic [31:0]             wdata,
    output logic [IDW-1:0]          grant_id
);

    // state | meaning
    // IDLE  | arbitrate requesters, one write per cycle
    // CLEAR | write zero to registers 0..31, one per edge
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } stateT;

    stateT          state, stateNext;
    logic [IDW-1:0] rrPtr, rrPtrNext;
    logic [4:0]     clrCnt, clrCntNext;
    logic           decEnableNext;
    logic [4:0]     decSelNext;
    logic [31:0]    wdataNext;
    logic [IDW-1:0] grantIdNext;

    logic           anyReq;
    logic [IDW-1:0] winner;
    logic           accept;
    logic [4:0]     addrWin;
    logic [31:0]    dataWin;

    function automatic int wrapIdx(input int i);
        return (i >= NUM_REQ) ? i - NUM_REQ : i;
    endfunction

    // First requester at or after rrPtr, scanning cyclically.
    always_comb begin
        anyReq = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!anyReq && req[wrapIdx(int'(rrPtr) + k)]) begin
                anyReq = 1'b1;
                winner = IDW'(wrapIdx(int'(rrPtr) + k));
            end
        end
    end

    assign addrWin    = addr_flat[int'(winner)*5 +: 5];
    assign dataWin    = data_flat[int'(winner)*32 +: 32];
    assign accept     = (state == IDLE) && !clear_start && !reset && anyReq;
    assign ack        = accept ? (NUM_REQ'(1) << winner) : '0;
    assign clear_busy = (state == CLEAR);

    always_comb begin
        stateNext     = state;
        rrPtrNext     = rrPtr;
        clrCntNext    = clrCnt;
        decEnableNext = 1'b0;
        decSelNext    = dec_sel;
        wdataNext     = wdata;
        grantIdNext   = grant_id;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    stateNext  = CLEAR;
                    clrCntNext = 5'd0;
                end else if (accept) begin
                    decEnableNext = !(SUPPRESS_R0 && (addrWin == 5'd0));
                    decSelNext    = addrWin;
                    wdataNext     = dataWin;
                    grantIdNext   = winner;
                    rrPtrNext     = IDW'(wrapIdx(int'(winner) + 1));
                end
            end
            CLEAR: begin
                decEnableNext = !(SUPPRESS_R0 && (clrCnt == 5'd0));
                decSelNext    = clrCnt;
                wdataNext     = 32'd0;
                grantIdNext   = '0;
                clrCntNext    = clrCnt + 5'd1;
                if (clrCnt == 5'd31) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rrPtr      <= '0;
            clrCnt     <= 5'd0;
            dec_enable <= 1'b0;
            dec_sel    <= 5'd0;
            wdata      <= 32'd0;
            grant_id   <= '0;
        end else begin
            state      <= stateNext;
            rrPtr      <= rrPtrNext;
            clrCnt     <= clrCntNext;
            dec_enable <= decEnableNext;
            dec_sel    <= decSelNext;
            wdata      <= wdataNext;
            grant_id   <= grantIdNext;
        end
    end

endmodule
